weight_sram_param: RTL

- Parametrised successor to the team's 32x2304 weight SRAM.
- Holds ROWS rows of WORD_W*WORDS_PER_ROW bits. Rows are written one WORD_W-bit word at a time through a streaming valid/ready load engine with auto-incrementing column and row. Reads return a full row to the CIM macro.
- Adds a command-driven burst-load FSM, per-row "loaded" flags, a read-valid strobe and held read data. It replaces the manual per-word column addressing and the tri-stated read output.

---
 rtl/weight_sram_param.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/weight_sram_param.sv
// Parametrised weight SRAM: ROWS rows of WORD_W*WORDS_PER_ROW bits, filled by a
// command-driven streaming burst-load engine and read a full row at a time.
module weight_sram_param #(
    parameter  int ROWS          = 32,
    parameter  int WORD_W        = 32,
    parameter  int WORDS_PER_ROW = 72,
    localparam int ROW_W         = WORD_W * WORDS_PER_ROW,
    localparam int RA_W          = $clog2(ROWS),
    localparam int CA_W          = $clog2(WORDS_PER_ROW),
    localparam int NW_W          = $clog2(ROWS * WORDS_PER_ROW + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ld_start,
    input  logic [RA_W-1:0]   ld_row,
    input  logic [NW_W-1:0]   ld_nwords,
    input  logic              wr_valid,
    input  logic [WORD_W-1:0] wr_data,
    output logic              wr_ready,
    output logic              ld_busy,
    output logic              ld_done,
    input  logic              rd_en,
    input  logic [RA_W-1:0]   rd_row,
    output logic [ROW_W-1:0]  rd_data,
    output logic              rd_valid,
    output logic [ROWS-1:0]   row_loaded,
    output logic [1:0]        dbg_state
);

    // Write handshake: a word transfers on any rising edge where wr_valid and
    // wr_ready are both high. wr_ready is a function of FSM state only (high in
    // LOAD), so a producer may hold wr_valid low for any number of cycles.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [NW_W-1:0] TOTAL_WORDS = NW_W'(ROWS * WORDS_PER_ROW);

    state_t            state_q;
    logic [RA_W-1:0]   row_q, row_d;
    logic [CA_W-1:0]   col_q, col_d;
    logic [NW_W-1:0]   rem_q, rem_d;
    logic [NW_W-1:0]   nwords_clamped;
    logic              col_last;
    logic              wr_fire;
    logic              wr_ready_q;
    logic              ld_busy_q;
    logic              ld_done_q;
    logic [ROWS-1:0]   row_loaded_q;
    logic [ROW_W-1:0]  rd_data_q;
    logic              rd_valid_q;
    logic [ROW_W-1:0]  mem_q [ROWS];

    assign wr_fire = wr_valid & wr_ready_q;

    always_comb begin
        col_last       = (col_q == CA_W'(WORDS_PER_ROW - 1));
        col_d          = col_last ? '0 : col_q + 1'b1;
        row_d          = row_q;
        if (col_last) begin
            row_d = (row_q == RA_W'(ROWS - 1)) ? '0 : row_q + 1'b1;
        end
        rem_d          = rem_q - 1'b1;
        nwords_clamped = (ld_nwords > TOTAL_WORDS) ? TOTAL_WORDS : ld_nwords;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            row_q      <= '0;
            col_q      <= '0;
            rem_q      <= '0;
            wr_ready_q <= 1'b0;
            ld_busy_q  <= 1'b0;
            ld_done_q  <= 1'b0;
        end else begin
            ld_done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (ld_start) begin
                        if (ld_nwords != '0) begin
                            row_q      <= ld_row;
                            col_q      <= '0;
                            rem_q      <= nwords_clamped;
                            wr_ready_q <= 1'b1;
                            ld_busy_q  <= 1'b1;
                            state_q    <= S_LOAD;
                        end else begin
                            ld_done_q <= 1'b1;
                            state_q   <= S_DONE;
                        end
                    end
                end
                S_LOAD: begin
                    if (wr_fire) begin
                        col_q <= col_d;
                        row_q <= row_d;
                        rem_q <= rem_d;
                        if (rem_q == NW_W'(1)) begin
                            wr_ready_q <= 1'b0;
                            ld_busy_q  <= 1'b0;
                            ld_done_q  <= 1'b1;
                            state_q    <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    wr_ready_q <= 1'b0;
                    ld_busy_q  <= 1'b0;
                    state_q    <= S_IDLE;
                end
            endcase
        end
    end

    // A row counts as loaded only once its last column lands after its first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_loaded_q <= '0;
        end else if (wr_fire) begin
            if (col_q == '0) begin
                row_loaded_q[row_q] <= 1'b0;
            end
            if (col_last) begin
                row_loaded_q[row_q] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem_q[row_q][int'(col_q) * WORD_W +: WORD_W] <= wr_data;
        end
    end

    // Sampling mem_q here sees the pre-edge contents, giving read-before-write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= rd_en;
            if (rd_en) begin
                rd_data_q <= mem_q[rd_row];
            end
        end
    end

    assign wr_ready   = wr_ready_q;
    assign ld_busy    = ld_busy_q;
    assign ld_done    = ld_done_q;
    assign rd_data    = rd_data_q;
    assign rd_valid   = rd_valid_q;
    assign row_loaded = row_loaded_q;
    assign dbg_state  = state_q;

endmodule
